// File: rtl/sprite_pkg.sv
// Shared constants, types and the clamp helper for the sprite position scheduler.
package sprite_pkg;

  localparam int NUM_SPRITES = 4;
  localparam int MAX_ROW     = 1199;
  localparam int MAX_COL     = 1599;
  localparam int RST_ROW     = 600;
  localparam int RST_COL     = 800;
  localparam int FCNT_W      = 16;
  localparam int ROW_W       = 11;
  localparam int COL_W       = 12;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } pos_t;

  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } sched_state_e;

  // Saturate a requested centre position to the legal screen area; never wraps.
  function automatic pos_t clamp_pos(input logic [ROW_W-1:0] row,
                                     input logic [COL_W-1:0] col,
                                     input logic [ROW_W-1:0] max_row,
                                     input logic [COL_W-1:0] max_col);
    pos_t p;
    p.row = (row > max_row) ? max_row : row;
    p.col = (col > max_col) ? max_col : col;
    return p;
  endfunction

endpackage

// File: rtl/sprite_position_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the lowest-index request at or after rr_ptr, wrapping.
// The pointer moves to just past the winner so every requester gets a fair turn.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clock_162,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] rr_ptr_reg;
  logic [PTR_W-1:0] rr_ptr_next;
  logic             found;
  int               cand;

  // Search from rr_ptr upward with wrap; the first asserted request wins.
  always_comb begin
    gnt         = '0;
    rr_ptr_next = rr_ptr_reg;
    found       = 1'b0;
    cand        = 0;
    for (int off = 0; off < N; off++) begin
      cand = (int'(rr_ptr_reg) + off) % N;
      if (en && !found && req[cand[PTR_W-1:0]]) begin
        found                   = 1'b1;
        gnt[cand[PTR_W-1:0]]    = 1'b1;
        rr_ptr_next             = (cand == N - 1) ? '0 : PTR_W'(cand + 1);
      end
    end
  end

  // Pointer advances only when somebody was granted.
  always_ff @(posedge clock_162) begin
    if (rst) begin
      rr_ptr_reg <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end

endmodule

// File: rtl/sprite_position_scheduler.sv
// Collects sprite position updates from the physics requesters into shadow registers
// and publishes them to the VGA driver in a single cycle right after VSYNC falls,
// so a frame never shows a half-applied set of positions.
module sprite_position_scheduler #(
  parameter int NUM_SPRITES = sprite_pkg::NUM_SPRITES,
  parameter int MAX_ROW     = sprite_pkg::MAX_ROW,
  parameter int MAX_COL     = sprite_pkg::MAX_COL,
  parameter int RST_ROW     = sprite_pkg::RST_ROW,
  parameter int RST_COL     = sprite_pkg::RST_COL,
  parameter int FCNT_W      = sprite_pkg::FCNT_W
) (
  input  logic                                          clock_162,
  input  logic                                          rst,
  input  logic                                          vsync,
  input  logic [NUM_SPRITES-1:0]                        req,
  input  logic [NUM_SPRITES-1:0][sprite_pkg::ROW_W-1:0] req_row,
  input  logic [NUM_SPRITES-1:0][sprite_pkg::COL_W-1:0] req_col,
  output logic [NUM_SPRITES-1:0]                        gnt,
  output logic [NUM_SPRITES-1:0]                        pending,
  output logic [NUM_SPRITES-1:0][sprite_pkg::ROW_W-1:0] sprite_row,
  output logic [NUM_SPRITES-1:0][sprite_pkg::COL_W-1:0] sprite_col,
  output logic                                          frame_tick,
  output logic [FCNT_W-1:0]                             frame_count
);

  import sprite_pkg::*;

  localparam logic [ROW_W-1:0] MAX_ROW_V = ROW_W'(MAX_ROW);
  localparam logic [COL_W-1:0] MAX_COL_V = COL_W'(MAX_COL);
  localparam pos_t             RST_POS   = {ROW_W'(RST_ROW), COL_W'(RST_COL)};

  sched_state_e           state_reg;
  logic                   vsync_q_reg;
  logic [NUM_SPRITES-1:0] pending_reg;
  logic [NUM_SPRITES-1:0] pending_next;
  logic [FCNT_W-1:0]      frame_count_reg;
  pos_t                   shadow_reg  [NUM_SPRITES];
  pos_t                   shadow_next [NUM_SPRITES];
  pos_t                   sprite_reg  [NUM_SPRITES];
  pos_t                   sprite_next [NUM_SPRITES];
  pos_t                   req_pos     [NUM_SPRITES];

  logic                   vsync_fall;
  logic                   commit;
  logic                   grant_en;
  logic [NUM_SPRITES-1:0] gnt_w;

  // VSYNC is active-low: its falling edge marks the start of the sync pulse.
  assign vsync_fall = vsync_q_reg & ~vsync;
  assign commit     = (state_reg == COMMIT);
  // No grants during reset or during the commit cycle, so shadow/pending are stable while copied.
  assign grant_en   = ~rst & ~commit;

  rr_arbiter #(
    .N (NUM_SPRITES)
  ) u_arb (
    .clock_162 (clock_162),
    .rst       (rst),
    .en        (grant_en),
    .req       (req),
    .gnt       (gnt_w)
  );

  generate
    for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_sprite
      assign req_pos[gi]      = clamp_pos(req_row[gi], req_col[gi], MAX_ROW_V, MAX_COL_V);
      // Last grant before the commit wins.
      assign shadow_next[gi]  = gnt_w[gi] ? req_pos[gi] : shadow_reg[gi];
      assign pending_next[gi] = commit ? 1'b0 : (pending_reg[gi] | gnt_w[gi]);
      // Untouched sprites keep their committed position across the commit.
      assign sprite_next[gi]  = (commit && pending_reg[gi]) ? shadow_reg[gi] : sprite_reg[gi];
      assign sprite_row[gi]   = sprite_reg[gi].row;
      assign sprite_col[gi]   = sprite_reg[gi].col;
    end
  endgenerate

  assign gnt         = gnt_w;
  assign pending     = pending_reg;
  assign frame_tick  = commit;
  assign frame_count = frame_count_reg;

  // Scheduler FSM plus shadow, committed-position, pending and frame-counter registers.
  always_ff @(posedge clock_162) begin
    if (rst) begin
      state_reg       <= IDLE;
      vsync_q_reg     <= 1'b1;
      pending_reg     <= '0;
      frame_count_reg <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        shadow_reg[i] <= RST_POS;
        sprite_reg[i] <= RST_POS;
      end
    end else begin
      vsync_q_reg <= vsync;
      pending_reg <= pending_next;
      shadow_reg  <= shadow_next;
      sprite_reg  <= sprite_next;
      case (state_reg)
        IDLE: begin
          if (vsync_fall) begin
            state_reg <= COMMIT;
          end
        end
        COMMIT: begin
          state_reg       <= IDLE;
          frame_count_reg <= frame_count_reg + 1'b1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
